// File: rtl/cfg_loader_pkg.sv
// Shared types for the config loader: FSM state encoding and index sizing.
package cfg_loader_pkg;

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DROP     = 2'd1,
        WAIT_RDY = 2'd2,
        WRITE    = 2'd3
    } state_t;

    // Index counter width; a one-word vector still needs a 1-bit index.
    function automatic int idx_width(input int num_inputs);
        return (num_inputs > 0) ? $clog2(num_inputs + 1) : 1;
    endfunction

endpackage

// File: rtl/config_loader.sv
// Config loader: assembles NUM_INPUTS+1 serial network words into a vector,
// hands it to the config memory over write_en/write_rdy/write_ack, flags
// short/long frames and counts committed frames.
module config_loader
    import cfg_loader_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int NUM_INPUTS = 8,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             write_en,
    input  logic             write_rdy,
    output logic [WIDTH-1:0] w_data_out [NUM_INPUTS:0],
    input  logic             write_ack,
    output logic             done,
    output logic             err_short,
    output logic             err_long,
    input  logic             err_clr,
    output logic [CNT_W-1:0] frame_count
);

    localparam int               IDX_W   = idx_width(NUM_INPUTS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_INPUTS);

    typedef logic [WIDTH-1:0] word_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    word_t            buf_q [NUM_INPUTS:0];
    word_t            buf_d [NUM_INPUTS:0];
    logic             write_en_q, write_en_d;
    logic             done_q, done_d;
    logic             err_short_q, err_short_d;
    logic             err_long_q, err_long_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;
    logic             at_last_idx;

    // Ready is a pure state decode, held low while reset is asserted so the
    // network never sees a transfer during reset.
    assign in_ready    = ~reset & ((state_q == COLLECT) | (state_q == DROP));
    assign xfer        = in_valid & in_ready;
    assign at_last_idx = (idx_q == IDX_MAX);

    assign write_en    = write_en_q;
    assign done        = done_q;
    assign err_short   = err_short_q;
    assign err_long    = err_long_q;
    assign frame_count = cnt_q;
    assign w_data_out  = buf_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= COLLECT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            COLLECT: begin
                if (xfer && at_last_idx) begin
                    state_d = in_last ? WAIT_RDY : DROP;
                end
            end
            DROP: begin
                if (xfer && in_last) begin
                    state_d = COLLECT;
                end
            end
            WAIT_RDY: begin
                if (write_rdy) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Ack is only honoured here; write_rdy dropping is ignored.
                if (write_ack) begin
                    state_d = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    // FSM output / datapath next-state decode; an error set beats a clear.
    always_comb begin
        idx_d       = idx_q;
        buf_d       = buf_q;
        write_en_d  = write_en_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        err_short_d = err_short_q & ~err_clr;
        err_long_d  = err_long_q & ~err_clr;
        case (state_q)
            COLLECT: begin
                if (xfer) begin
                    buf_d[idx_q] = in_data;
                    if (at_last_idx) begin
                        idx_d = '0;
                        if (!in_last) begin
                            err_long_d = 1'b1;
                        end
                    end else if (in_last) begin
                        // Partial buffer stays uncommitted; next frame overwrites it.
                        idx_d       = '0;
                        err_short_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            WAIT_RDY: begin
                if (write_rdy) begin
                    write_en_d = 1'b1;
                end
            end
            WRITE: begin
                if (write_ack) begin
                    write_en_d = 1'b0;
                    done_d     = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset discards any in-flight frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q       <= '0;
            write_en_q  <= 1'b0;
            done_q      <= 1'b0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
            cnt_q       <= '0;
            for (int i = 0; i <= NUM_INPUTS; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            write_en_q  <= write_en_d;
            done_q      <= done_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
        end
    end

endmodule

// File: doc/config_loader.md
Name: config_loader

Overview:
- Upstream neighbour of the vector-tile config memory.
- Accepts configuration words serially from the CGRA network (valid/ready stream with frame-end marker) and assembles NUM_INPUTS+1 words into a vector buffer.
- Presents the vector to the config memory write port using the write_en / write_rdy / write_ack handshake.
- Detects malformed frames (short/long) and counts committed frames.

Parameters:
- WIDTH, 16, bits per config word.
- NUM_INPUTS, 8, vector holds NUM_INPUTS+1 words (indices 0..NUM_INPUTS).
- CNT_W, 16, width of committed-frame counter.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_valid  input  1  network word valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  WIDTH  network word.
- in_last  input  1  marks final word of a frame.
- write_en  output  1  request to config memory; held until ack.
- write_rdy  input  1  config memory idle and able to take a write.
- w_data_out  output  WIDTH x (NUM_INPUTS+1)  unpacked array [NUM_INPUTS:0]; assembled vector.
- write_ack  input  1  config memory write completed.
- done  output  1  one-cycle pulse when a frame is committed.
- err_short  output  1  sticky: frame ended before NUM_INPUTS+1 words.
- err_long  output  1  sticky: frame had more than NUM_INPUTS+1 words.
- err_clr  input  1  clears both sticky error flags.
- frame_count  output  CNT_W  committed frames; wraps at 2^CNT_W.

Behaviour:
- Reset values: in_ready=0, write_en=0, done=0, err_short=0, err_long=0, frame_count=0, all w_data_out words=0. Index counter=0. State=COLLECT.
- A word transfer happens on a clk edge where in_valid && in_ready.
- All outputs are registered except in_ready and w_data_out, which are decoded directly from state / buffer registers.
- COLLECT:
  - in_ready=1.
  - Each transfer writes in_data to buffer[idx].
  - idx<NUM_INPUTS, in_last=0: idx++.
  - idx<NUM_INPUTS, in_last=1: set err_short, idx<=0, stay COLLECT. The partial buffer is not committed.
  - idx==NUM_INPUTS, in_last=1: idx<=0, go to WAIT_RDY.
  - idx==NUM_INPUTS, in_last=0: set err_long, idx<=0, go to DROP.
- DROP:
  - in_ready=1; transfers are discarded.
  - A transfer with in_last=1 returns to COLLECT.
- WAIT_RDY:
  - in_ready=0.
  - write_rdy=1 sampled: write_en<=1, go to WRITE.
- WRITE:
  - in_ready=0, write_en=1; w_data_out held stable.
  - write_ack=1 sampled: write_en<=0, done<=1 for one cycle, frame_count++, go to COLLECT.
  - write_ack is level-sensitive. Only the first cycle seen in WRITE counts; ack in any other state is ignored.
- Latency:
  - Last word accepted at edge N: earliest write_en=1 after edge N+1 (one cycle in WAIT_RDY, write_rdy=1).
  - Ack sampled at edge M: write_en=0 and done=1 after edge M; in_ready=1 in cycle after edge M.
- w_data_out always reflects the buffer.
  - Buffer changes only in COLLECT, so it is constant from entry to WAIT_RDY until return to COLLECT.
  - After a short frame the buffer holds stale mixed words; this is harmless because only WAIT_RDY/WRITE imply validity.
- Error flags:
  - err_clr clears both flags.
  - A set and a clear in the same cycle: set wins.
- Single-word case: if NUM_INPUTS=0, a one-word frame with in_last=1 goes straight to WAIT_RDY.
- Reset mid-operation (any state): return to reset values next edge. write_en drops immediately and the in-flight frame is discarded; config memory's own reset handles its side.
- write_rdy deasserting while in WRITE is ignored; write_en stays high until ack.

Decomposition:
- Package cfg_loader_pkg holds:
  - typedef enum logic [1:0] state_t {COLLECT, DROP, WAIT_RDY, WRITE}.
  - Word type parameterized by WIDTH, or supplied as a localparam in the module.
- No sub-module required. Buffer, index counter and FSM live in one module; expected size ~150-200 lines.

Test Plan (NUM_INPUTS=8, WIDTH=16):
- Nominal frame:
  - Stimulus: words 0x0001..0x0009, in_last on 9th; write_rdy=1; write_ack pulsed 2 cycles after write_en.
  - Response: w_data_out[0..8]=0x0001..0x0009; write_en high until ack edge; done pulses once; frame_count=1.
- Short frame:
  - Stimulus: 5 words with in_last on 5th, then a valid 9-word frame 0x0100..0x0108.
  - Response: err_short=1; only second frame committed (w_data_out[8]=0x0108); frame_count=1.
- Long frame:
  - Stimulus: 12 words, in_last on 12th.
  - Response: err_long=1; words 10-12 consumed with in_ready=1; no write_en; then err_clr -> both flags 0.
- Backpressure:
  - Stimulus: frame complete with write_rdy=0 for 10 cycles.
  - Response: in_ready=0 and write_en=0 throughout; write_en rises the cycle after write_rdy=1; extra in_valid words stall and are not lost.
- Reset mid-write:
  - Stimulus: assert reset while write_en=1, before ack.
  - Response: next cycle write_en=0, frame_count=0, w_data_out all 0, in_ready=1 after reset release.
- Counter wrap:
  - Stimulus: CNT_W=2, commit 5 frames.
  - Response: frame_count sequence 1,2,3,0,1.
